dmem_ctrl: RTL and testbench

- Parametrised data-memory stage for the pipelined Y86 core; successor to the single-cycle combinational-read RAM.
- Sits between the M pipeline register and W: accepts one load/store request, performs a sized, bounds- and alignment-checked access with configurable latency, and returns data plus status.
- Drives a stall to the pipeline control while an access is outstanding.

---
 rtl/dmem_ctrl_pkg.sv | 29 ++
 rtl/dmem_ctrl_if.sv | 27 ++
 rtl/dmem_array.sv | 31 +++
 rtl/dmem_ctrl.sv | 141 ++++++++++++++
 tb/tb_dmem_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_ctrl_pkg.sv
// Shared types for the Y86 data-memory stage: status codes, access size codes
// and controller FSM state encoding.
package dmem_ctrl_pkg;

    localparam logic [2:0] SAOK = 3'h1;
    localparam logic [2:0] SADR = 3'h2;

    typedef enum logic [1:0] {
        DSZ_B = 2'd0,
        DSZ_W = 2'd1,
        DSZ_L = 2'd2,
        DSZ_Q = 2'd3
    } dsize_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2,
        ST_ERR  = 2'd3
    } state_e;

    // Sizes wider than the data bus collapse to the widest access the bus carries.
    function automatic dsize_e cap_size(input logic [1:0] size, input int unsigned max_sz);
        logic [1:0] max_code;
        max_code = max_sz[1:0];
        return (size > max_code) ? dsize_e'(max_code) : dsize_e'(size);
    endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// Request/response bus between the M pipeline stage and the data-memory stage.
interface dmem_ctrl_if #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64
);
    logic              req_valid_i;
    logic              req_ready_o;
    logic              req_we_i;
    logic [1:0]        req_size_i;
    logic [ADDR_W-1:0] req_addr_i;
    logic [DATA_W-1:0] req_wdata_i;
    logic [2:0]        req_stat_i;
    logic              resp_valid_o;
    logic [DATA_W-1:0] resp_rdata_o;
    logic [2:0]        resp_stat_o;
    logic              stall_o;

    modport master (
        output req_valid_i, req_we_i, req_size_i, req_addr_i, req_wdata_i, req_stat_i,
        input  req_ready_o, resp_valid_o, resp_rdata_o, resp_stat_o, stall_o
    );

    modport slave (
        input  req_valid_i, req_we_i, req_size_i, req_addr_i, req_wdata_i, req_stat_i,
        output req_ready_o, resp_valid_o, resp_rdata_o, resp_stat_o, stall_o
    );
endinterface

// File: rtl/dmem_array.sv
// Byte-addressed data storage: per-byte synchronous write, registered read of
// DATA_W/8 consecutive bytes starting at addr_i (indices wrap modulo DEPTH).
module dmem_array #(
    parameter int unsigned DEPTH  = 2048,
    parameter int unsigned DATA_W = 64
) (
    input  logic                     clk_i,
    input  logic [$clog2(DEPTH)-1:0] addr_i,
    input  logic [DATA_W/8-1:0]      wbe_i,
    input  logic [DATA_W-1:0]        wdata_i,
    input  logic                     re_i,
    output logic [DATA_W-1:0]        rdata_o
);
    localparam int unsigned NB = DATA_W / 8;
    localparam int unsigned AW = $clog2(DEPTH);

    logic [7:0]        mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // NOTE: neither the storage nor the read register is reset; the controller
    // state alone decides whether rdata_q is ever presented.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NB; i++) begin
            if (wbe_i[i]) mem_q[addr_i + AW'(i)] <= wdata_i[8*i +: 8];
            if (re_i)     rdata_q[8*i +: 8]      <= mem_q[addr_i + AW'(i)];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory stage controller: accepts one load/store, checks bounds and
// alignment, waits the configured latency and returns a one-cycle response.
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH     = 2048,
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned ADDR_W    = 64,
    parameter int unsigned RD_LAT    = 2,
    parameter int unsigned WR_LAT    = 1,
    parameter int unsigned ALIGN_CHK = 1
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    dmem_ctrl_if.slave  bus
);
    localparam int unsigned NB      = DATA_W / 8;
    localparam int unsigned AW      = $clog2(DEPTH);
    localparam int unsigned AW1     = ADDR_W + 1;
    localparam int unsigned MAX_SZ  = $clog2(NB);
    localparam int unsigned MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
    localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);
    localparam logic [CNT_W-1:0] RD_CNT = CNT_W'(RD_LAT - 1);
    localparam logic [CNT_W-1:0] WR_CNT = CNT_W'(WR_LAT - 1);
    localparam logic [NB-1:0]    ONES   = '1;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    dsize_e            size_q, size_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [2:0]        stat_q, stat_d;

    dsize_e            req_size;
    logic [AW1-1:0]    req_nbytes, req_end;
    logic              req_err;

    logic [NB-1:0]     be, arr_wbe;
    logic [DATA_W-1:0] byte_mask, arr_rdata;
    logic              access, arr_re;

    // The end address is one bit wider than the bus so a wrap past 2^ADDR_W is out of range.
    always_comb begin
        req_size   = cap_size(bus.req_size_i, MAX_SZ);
        req_nbytes = AW1'(1) << req_size;
        req_end    = {1'b0, bus.req_addr_i} + req_nbytes;
        req_err    = (req_end > AW1'(DEPTH)) ||
                     ((ALIGN_CHK != 0) && (({1'b0, bus.req_addr_i} & (req_nbytes - AW1'(1))) != '0));
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            size_q  <= DSZ_B;
            addr_q  <= '0;
            wdata_q <= '0;
            stat_q  <= SAOK;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            stat_q  <= stat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        stat_d  = stat_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.req_valid_i) begin
                    we_d    = bus.req_we_i;
                    size_d  = req_size;
                    addr_d  = bus.req_addr_i[AW-1:0];
                    wdata_d = bus.req_wdata_i;
                    stat_d  = bus.req_stat_i;
                    if (req_err) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d = ST_BUSY;
                        cnt_d   = bus.req_we_i ? WR_CNT : RD_CNT;
                    end
                end
            end
            ST_BUSY: begin
                if (cnt_q == '0) state_d = ST_RESP;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            ST_RESP, ST_ERR: state_d = ST_IDLE;
            default:         state_d = ST_IDLE;
        endcase
    end

    // The array is touched only in the last BUSY cycle, so the store commits and
    // the load data is captured on the same edge that enters RESP.
    always_comb begin
        be        = ~(ONES << (32'd1 << size_q));
        byte_mask = '0;
        for (int i = 0; i < NB; i++) byte_mask[8*i +: 8] = {8{be[i]}};

        access  = (state_q == ST_BUSY) && (cnt_q == '0) && (stat_q == SAOK);
        arr_wbe = (access && we_q) ? be : '0;
        arr_re  = access && !we_q;

        bus.req_ready_o  = (state_q == ST_IDLE);
        bus.stall_o      = (state_q != ST_IDLE);
        bus.resp_valid_o = (state_q == ST_RESP) || (state_q == ST_ERR);
        bus.resp_stat_o  = SAOK;
        bus.resp_rdata_o = '0;
        if (state_q == ST_ERR) begin
            bus.resp_stat_o = SADR;
        end else if (state_q == ST_RESP) begin
            bus.resp_stat_o = stat_q;
            if (!we_q && stat_q == SAOK) bus.resp_rdata_o = arr_rdata & byte_mask;
        end
    end

    dmem_array #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_array (
        .clk_i   (clk_i),
        .addr_i  (addr_q),
        .wbe_i   (arr_wbe),
        .wdata_i (wdata_q),
        .re_i    (arr_re),
        .rdata_o (arr_rdata)
    );

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: each accepted request pushes its expected
// status, data and response cycle; every response pops and compares.
module tb_dmem_ctrl;
    localparam int DEPTH  = 2048;
    localparam int RD_LAT = 2;
    localparam int WR_LAT = 1;

    localparam logic [2:0] T_SAOK = 3'h1;
    localparam logic [2:0] T_SADR = 3'h2;
    localparam logic [2:0] T_SINS = 3'h3;
    localparam logic [2:0] T_SHLT = 3'h4;

    typedef struct {
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        int          nb;
        logic        commit;
        logic [2:0]  stat;
        logic [63:0] rdata;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    dmem_ctrl_if #(.ADDR_W(64), .DATA_W(64)) bus ();

    dmem_ctrl #(
        .DEPTH(DEPTH), .DATA_W(64), .ADDR_W(64),
        .RD_LAT(RD_LAT), .WR_LAT(WR_LAT), .ALIGN_CHK(1)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    exp_t        exp_q[$];
    logic [7:0]  mem_m [DEPTH];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    bit          last_fire = 0;
    string       cur = "init";

    // Reference behaviour of one accepted request, computed from the bench's own byte model.
    function automatic void push_exp();
        exp_t        e;
        logic [64:0] endp;
        logic        err;
        e.we     = bus.req_we_i;
        e.addr   = bus.req_addr_i;
        e.wdata  = bus.req_wdata_i;
        e.nb     = 1 << bus.req_size_i;
        e.commit = 1'b0;
        e.rdata  = '0;
        endp     = {1'b0, e.addr} + 65'(e.nb);
        err      = (endp > 65'(DEPTH)) || ((e.addr % 64'(e.nb)) != 0);
        if (err) begin
            e.stat = T_SADR;
            e.due  = cyc;
        end else begin
            e.stat = bus.req_stat_i;
            e.due  = cyc + (e.we ? WR_LAT : RD_LAT);
            if (e.stat == T_SAOK) begin
                if (e.we) e.commit = 1'b1;
                else for (int i = 0; i < e.nb; i++)
                    e.rdata[8*i +: 8] = mem_m[int'(e.addr[10:0]) + i];
            end
        end
        exp_q.push_back(e);
    endfunction

    task automatic step();
        bit   fire;
        bit   busy;
        exp_t e;
        fire = bus.req_valid_i && bus.req_ready_o;
        @(posedge clk);
        #1;
        cyc++;
        last_fire = fire;
        if (fire) push_exp();
        busy = (exp_q.size() > 0);
        checks++;
        if (bus.stall_o !== busy) begin
            failures++;
            $display("FAIL %s stall cyc=%0d got=%b exp=%b", cur, cyc, bus.stall_o, busy);
        end
        checks++;
        if (bus.req_ready_o !== !busy) begin
            failures++;
            $display("FAIL %s ready cyc=%0d got=%b exp=%b", cur, cyc, bus.req_ready_o, !busy);
        end
        if (bus.resp_valid_o === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL %s unexpected_resp cyc=%0d got=1 exp=0", cur, cyc);
            end else begin
                e = exp_q.pop_front();
                if (e.commit) for (int i = 0; i < e.nb; i++)
                    mem_m[int'(e.addr[10:0]) + i] = e.wdata[8*i +: 8];
                if (cyc != e.due) begin
                    failures++;
                    $display("FAIL %s latency got_cyc=%0d exp_cyc=%0d", cur, cyc, e.due);
                end
                checks++;
                if (bus.resp_stat_o !== e.stat) begin
                    failures++;
                    $display("FAIL %s stat got=%0h exp=%0h", cur, bus.resp_stat_o, e.stat);
                end
                checks++;
                if (bus.resp_rdata_o !== e.rdata) begin
                    failures++;
                    $display("FAIL %s rdata got=%016h exp=%016h", cur, bus.resp_rdata_o, e.rdata);
                end
            end
        end else if (exp_q.size() > 0 && cyc > exp_q[0].due) begin
            checks++;
            failures++;
            $display("FAIL %s missing_resp cyc=%0d exp_cyc=%0d", cur, cyc, exp_q[0].due);
            void'(exp_q.pop_front());
        end
    endtask

    task automatic set_req(input logic we, input logic [1:0] size, input logic [63:0] addr,
                           input logic [63:0] wdata, input logic [2:0] stat);
        bus.req_we_i    = we;
        bus.req_size_i  = size;
        bus.req_addr_i  = addr;
        bus.req_wdata_i = wdata;
        bus.req_stat_i  = stat;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 20) begin
            step();
            n++;
        end
    endtask

    task automatic issue(input logic we, input logic [1:0] size, input logic [63:0] addr,
                         input logic [63:0] wdata, input logic [2:0] stat);
        int n = 0;
        set_req(we, size, addr, wdata, stat);
        bus.req_valid_i = 1'b1;
        do begin
            step();
            n++;
        end while (!last_fire && n < 20);
        bus.req_valid_i = 1'b0;
        if (!last_fire) begin
            checks++;
            failures++;
            $display("FAIL %s accept_timeout addr=%016h", cur, addr);
        end
        drain();
    endtask

    task automatic test_reset();
        cur = "reset";
        bus.req_valid_i = 1'b0;
        set_req(1'b0, 2'd0, 64'h0, 64'h0, T_SAOK);
        step();
        step();
        checks++;
        if (bus.resp_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL reset resp_valid got=%b exp=0", bus.resp_valid_o);
        end
        checks++;
        if (bus.resp_rdata_o !== 64'h0) begin
            failures++;
            $display("FAIL reset rdata got=%016h exp=0", bus.resp_rdata_o);
        end
        checks++;
        if (bus.resp_stat_o !== T_SAOK) begin
            failures++;
            $display("FAIL reset stat got=%0h exp=%0h", bus.resp_stat_o, T_SAOK);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_store_load();
        cur = "store_load";
        issue(1'b1, 2'd3, 64'h100, 64'h1122334455667788, T_SAOK);
        issue(1'b0, 2'd3, 64'h100, 64'h0, T_SAOK);
    endtask

    task automatic test_byte_lanes();
        cur = "byte_lanes";
        issue(1'b1, 2'd0, 64'h103, 64'hFFFF_FFFF_FFFF_FFAB, T_SAOK);
        issue(1'b0, 2'd3, 64'h100, 64'h0, T_SAOK);
        issue(1'b0, 2'd1, 64'h102, 64'h0, T_SAOK);
        issue(1'b1, 2'd2, 64'h108, 64'h0102_0304_A1B2_C3D4, T_SAOK);
        issue(1'b0, 2'd2, 64'h108, 64'h0, T_SAOK);
        cur = "byte_lanes_abs";
        checks++;
        if ({mem_m[16'h107], mem_m[16'h106], mem_m[16'h105], mem_m[16'h104],
             mem_m[16'h103], mem_m[16'h102], mem_m[16'h101], mem_m[16'h100]} !== 64'h11223344AB667788) begin
            failures++;
            $display("FAIL byte_lanes_abs model got=%02h%02h%02h%02h exp=11223344", mem_m[16'h107],
                     mem_m[16'h106], mem_m[16'h105], mem_m[16'h104]);
        end
    endtask

    task automatic test_errors();
        cur = "errors";
        issue(1'b1, 2'd3, 64'h7F8, 64'h0BAD_F00D_DEAD_BEEF, T_SAOK);
        issue(1'b0, 2'd3, 64'h7FC, 64'h0, T_SAOK);
        issue(1'b0, 2'd3, 64'h7F8, 64'h0, T_SAOK);
        issue(1'b0, 2'd0, 64'h800, 64'h0, T_SAOK);
        issue(1'b1, 2'd0, 64'h7FF, 64'h0000_0000_0000_005A, T_SAOK);
        issue(1'b0, 2'd0, 64'h7FF, 64'h0, T_SAOK);
        issue(1'b1, 2'd3, 64'hFFFF_FFFF_FFFF_FFFC, 64'h5555_5555_5555_5555, T_SAOK);
        issue(1'b1, 2'd3, 64'hFFFF_FFFF_FFFF_FFF8, 64'h6666_6666_6666_6666, T_SAOK);
        issue(1'b0, 2'd1, 64'h101, 64'h0, T_SAOK);
        issue(1'b0, 2'd3, 64'h7F8, 64'h0, T_SAOK);
    endtask

    task automatic test_stat_passthru();
        cur = "stat_passthru";
        issue(1'b1, 2'd3, 64'h100, 64'h9999_8888_7777_6666, T_SINS);
        issue(1'b0, 2'd3, 64'h100, 64'h0, T_SHLT);
        issue(1'b0, 2'd3, 64'h100, 64'h0, T_SAOK);
    endtask

    task automatic test_reset_midaccess();
        cur = "reset_mid";
        issue(1'b1, 2'd3, 64'h200, 64'hCAFE_BABE_0000_1234, T_SAOK);
        set_req(1'b1, 2'd3, 64'h200, 64'h0123_4567_89AB_CDEF, T_SAOK);
        bus.req_valid_i = 1'b1;
        step();
        bus.req_valid_i = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.stall_o !== 1'b0 || bus.req_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid stall_ready got=%b%b exp=01", bus.stall_o, bus.req_ready_o);
        end
        checks++;
        if (bus.resp_valid_o !== 1'b0 || bus.resp_stat_o !== T_SAOK) begin
            failures++;
            $display("FAIL reset_mid resp got=%b/%0h exp=0/%0h", bus.resp_valid_o, bus.resp_stat_o, T_SAOK);
        end
        exp_q.delete();
        step();
        rst_n = 1'b1;
        step();
        issue(1'b0, 2'd3, 64'h200, 64'h0, T_SAOK);
    endtask

    // With valid held high each request is accepted in IDLE only; the next one
    // follows after LAT busy cycles, the response cycle and one IDLE cycle.
    task automatic test_back_to_back();
        int idx = 0;
        int n = 0;
        int last_acc = -1;
        int last_lat = 0;
        cur = "back_to_back";
        set_req(1'b1, 2'd3, 64'h300, 64'hA000_0000_0000_0000, T_SAOK);
        bus.req_valid_i = 1'b1;
        while (idx < 6 && n < 100) begin
            step();
            n++;
            if (last_fire) begin
                if (last_acc >= 0) begin
                    checks++;
                    if (cyc - last_acc != last_lat + 2) begin
                        failures++;
                        $display("FAIL back_to_back gap got=%0d exp=%0d", cyc - last_acc, last_lat + 2);
                    end
                end
                last_acc = cyc;
                last_lat = bus.req_we_i ? WR_LAT : RD_LAT;
                idx++;
                if (idx[0]) set_req(1'b0, 2'd3, 64'h300 + 64'(8 * (idx / 2)), 64'h0, T_SAOK);
                else        set_req(1'b1, 2'd3, 64'h300 + 64'(8 * (idx / 2)),
                                    64'hA000_0000_0000_0000 + 64'(idx * 64'h1111), T_SAOK);
            end
        end
        bus.req_valid_i = 1'b0;
        if (idx < 6) begin
            checks++;
            failures++;
            $display("FAIL back_to_back accept_timeout got=%0d exp=6", idx);
        end
        drain();
    endtask

    initial begin
        bus.req_valid_i = 1'b0;
        test_reset();
        test_store_load();
        test_byte_lanes();
        test_errors();
        test_stat_passthru();
        test_reset_midaccess();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
